// File: rtl/gfx_target_reader.sv
// Purpose: read-side target fetch responder; one MDW-wide Wishbone read per request, optional one-line cache.
// Latency: ack_o two cycles after req_i on a first-cycle slave ack, one cycle on a cache hit.
// Backpressure: req_i is held until ack_o; busy_o is high outside IDLE; slave stalls are bounded by TIMEOUT.
// Optional feature: define GFX_TARGET_READER_CACHE_EN to enable the one-line cache.
module gfx_target_reader #(
   parameter int MDW     = 256,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [31:0]       addr_i,
   output logic              ack_o,
   output logic [MDW-1:0]    data_o,
   output logic              err_o,
   output logic              busy_o,
   input  logic              inv_i,
   output logic              m_cyc_o,
   output logic              m_stb_o,
   output logic              m_we_o,
   output logic [MDW/8-1:0]  m_sel_o,
   output logic [31:0]       m_adr_o,
   input  logic [MDW-1:0]    m_dat_i,
   input  logic              m_ack_i,
   input  logic              m_err_i
);

   localparam int LB = $clog2(MDW/8);
   localparam int TW = 32 - LB;

   typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             cyc_q, cyc_d;
   logic [MDW-1:0]   data_q, data_d;
   logic [31:0]      adr_q, adr_d;
   logic             hit;
   logic             tmo;
   logic             unused_ok;

   // The timeout fires in the TIMEOUT-th consecutive bus cycle without a slave response,
   // so ack_o+err_o lands exactly TIMEOUT cycles after m_cyc_o rises.
   assign tmo = ~m_ack_i & (cnt_q == 8'(TIMEOUT - 1));

`ifdef GFX_TARGET_READER_CACHE_EN
   logic             valid_q, valid_d;
   logic [TW-1:0]    tag_q, tag_d;
   logic [MDW-1:0]   line_q, line_d;
   // A same-cycle invalidate suppresses the hit: the renderer has just written the target.
   assign hit       = valid_q & ~inv_i & (tag_q == addr_i[31:LB]);
   assign unused_ok = ^addr_i[LB-1:0];
`else
   assign hit       = 1'b0;
   assign unused_ok = ^{inv_i, addr_i[LB-1:0]};
`endif

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         cyc_q   <= 1'b0;
         data_q  <= '0;
         adr_q   <= '0;
`ifdef GFX_TARGET_READER_CACHE_EN
         valid_q <= 1'b0;
         tag_q   <= '0;
         line_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         data_q  <= data_d;
         adr_q   <= adr_d;
`ifdef GFX_TARGET_READER_CACHE_EN
         valid_q <= valid_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
`endif
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_i) state_d = hit ? ACK : BUS;
         BUS:  if (m_ack_i | m_err_i | tmo) state_d = ACK;
         ACK:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, bus controls and cache
   always_comb begin
      ack_d  = 1'b0;
      err_d  = 1'b0;
      cyc_d  = cyc_q;
      data_d = data_q;
      adr_d  = adr_q;
      cnt_d  = cnt_q;
`ifdef GFX_TARGET_READER_CACHE_EN
      valid_d = valid_q & ~inv_i;
      tag_d   = tag_q;
      line_d  = line_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (hit) begin
`ifdef GFX_TARGET_READER_CACHE_EN
                  data_d = line_q;
`endif
                  ack_d  = 1'b1;
               end else begin
                  adr_d = {addr_i[31:LB], {LB{1'b0}}};
                  cyc_d = 1'b1;
                  cnt_d = '0;
               end
            end
         end
         BUS: begin
            if (m_err_i | tmo) begin
               // Error wins over a simultaneous ack; cache stays untouched.
               data_d = '0;
               ack_d  = 1'b1;
               err_d  = 1'b1;
               cyc_d  = 1'b0;
            end else if (m_ack_i) begin
               data_d = m_dat_i;
               ack_d  = 1'b1;
               cyc_d  = 1'b0;
`ifdef GFX_TARGET_READER_CACHE_EN
               tag_d   = adr_q[31:LB];
               line_d  = m_dat_i;
               valid_d = ~inv_i;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign data_o  = data_q;
   assign busy_o  = (state_q != IDLE);
   assign m_cyc_o = cyc_q;
   assign m_stb_o = cyc_q;
   assign m_we_o  = 1'b0;
   assign m_sel_o = {(MDW/8){cyc_q}};
   assign m_adr_o = adr_q;

endmodule
